// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle for imm_encoder.
//   Request side : in_valid, in_ready, in_imm[31:0], in_sel[2:0], in_base[31:0]
//   Response side: out_valid, out_ready, out_inst[31:0], out_err
//   master: producer of requests / consumer of results (e.g. a generator or bench)
//   slave : the encoder itself
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_sel;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_imm, in_sel, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_sel, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into a base instruction word using
// the RV32I immediate layouts (U/I/S/B/J/Zimm) and flags immediates that are
// not representable in the chosen format. Results are queued in a small
// in-order output FIFO.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : imm_encoder_if.slave (request valid/ready, response valid/ready)
//   err_count : saturating count of accepted requests flagged as errors
module imm_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        SEL_U = 3'b000,
        SEL_I = 3'b001,
        SEL_S = 3'b010,
        SEL_B = 3'b011,
        SEL_J = 3'b100,
        SEL_Z = 3'b101
    } sel_e;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [31:0] w_imm;
    logic [31:0] w_enc;
    logic        w_err;
    logic        w_fit12;   // imm[31:11] all equal: fits signed 12 bits
    logic        w_fit13;   // imm[31:12] all equal: fits signed 13 bits
    logic        w_fit21;   // imm[31:20] all equal: fits signed 21 bits

    assign w_imm   = bus.in_imm;
    assign w_fit12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    assign w_fit13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    assign w_fit21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

    always_comb begin
        w_enc = bus.in_base;
        w_err = 1'b0;
        case (sel_e'(bus.in_sel))
            SEL_U: begin
                w_enc[31:12] = w_imm[31:12];
                w_err        = |w_imm[11:0];
            end
            SEL_I: begin
                w_enc[31:20] = w_imm[11:0];
                w_err        = ~w_fit12;
            end
            SEL_S: begin
                w_enc[31:25] = w_imm[11:5];
                w_enc[11:7]  = w_imm[4:0];
                w_err        = ~w_fit12;
            end
            SEL_B: begin
                w_enc[31]    = w_imm[12];
                w_enc[30:25] = w_imm[10:5];
                w_enc[11:8]  = w_imm[4:1];
                w_enc[7]     = w_imm[11];
                w_err        = w_imm[0] | ~w_fit13;
            end
            SEL_J: begin
                w_enc[31]    = w_imm[20];
                w_enc[30:21] = w_imm[10:1];
                w_enc[20]    = w_imm[11];
                w_enc[19:12] = w_imm[19:12];
                w_err        = w_imm[0] | ~w_fit21;
            end
            SEL_Z: begin
                w_enc[19:15] = w_imm[4:0];
                w_err        = |w_imm[31:5];
            end
            default: begin
                // Reserved selector: pass the base word through, flagged.
                w_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      r_mem_inst [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_err_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full        = (r_count == CW'(DEPTH));
    assign bus.in_ready  = ~w_full & ~rst;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_inst  = r_mem_inst[r_rd_ptr];
    assign bus.out_err   = r_mem_err[r_rd_ptr];
    assign err_count     = r_err_count;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_count <= '0;
            // Storage is cleared so the head reads zero after reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_err[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_inst[r_wr_ptr] <= w_enc;
                r_mem_err[r_wr_ptr]  <= w_err;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
                if (w_err && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed, table-driven bench for imm_encoder plus
// hand-written sequences for backpressure, streaming, saturation and reset.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if bus ();
    imm_encoder_if bus2 ();
    logic [15:0] err_count;
    logic [1:0]  err_count2;

    imm_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .err_count (err_count)
    );

    // Narrow counter instance so saturation is reachable quickly.
    imm_encoder #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2.slave),
        .err_count (err_count2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] base,
                         input logic [31:0] imm);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_base  = base;
        bus.in_imm   = imm;
    endtask

    int exp_cnt;

    initial begin
        vecs[0]  = '{3'b001, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
        vecs[1]  = '{3'b001, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1};
        vecs[2]  = '{3'b011, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
        vecs[3]  = '{3'b011, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1};
        vecs[4]  = '{3'b000, 32'h0000_00B7, 32'h1234_5000, 32'h1234_50B7, 1'b0};
        vecs[5]  = '{3'b000, 32'h0000_00B7, 32'h1234_5001, 32'h1234_50B7, 1'b1};
        vecs[6]  = '{3'b100, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
        vecs[7]  = '{3'b101, 32'h0000_0073, 32'h0000_001F, 32'h000F_8073, 1'b0};
        vecs[8]  = '{3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
        vecs[9]  = '{3'b010, 32'h0000_0023, 32'hFFFF_FFFF, 32'hFE00_0FA3, 1'b0};
        vecs[10] = '{3'b010, 32'h0000_0023, 32'h0000_07FF, 32'h7E00_0FA3, 1'b0};
        vecs[11] = '{3'b001, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 1'b0};
        vecs[12] = '{3'b100, 32'h0000_006F, 32'h0000_0001, 32'h0000_006F, 1'b1};
        vecs[13] = '{3'b101, 32'h0000_0073, 32'h0000_0020, 32'h0000_0073, 1'b1};
        vecs[14] = '{3'b110, 32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1};
        vecs[15] = '{3'b000, 32'h0000_00B7, 32'hFFFF_F000, 32'hFFFF_F0B7, 1'b0};
        vecs[16] = '{3'b011, 32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
        vecs[17] = '{3'b011, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1};
        vecs[18] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 1'b0};

        drive(1'b0, 3'b000, '0, '0);
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_sel    = 3'b111;
        bus2.in_base   = '0;
        bus2.in_imm    = '0;
        bus2.out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // ---------------- table-driven encode checks ----------------
        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].sel, vecs[i].base, vecs[i].imm);
            @(posedge clk);
            #1;
            drive(1'b0, 3'b000, '0, '0);
            if (vecs[i].exp_err) exp_cnt++;
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d_inst", i), bus.out_inst, vecs[i].exp_inst);
            chk($sformatf("v%0d_err", i), 32'(bus.out_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_errcnt", i), 32'(err_count), 32'(exp_cnt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
        end

        // ---------------- backpressure A/B/C ----------------
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h0000_0013, 32'h0000_0001);            // A
        @(posedge clk); #1;
        chk("bp_A_head", bus.out_inst, 32'h0010_0013);
        drive(1'b1, 3'b001, 32'h0000_0013, 32'h0000_0002);            // B
        @(posedge clk); #1;
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 3'b001, 32'h0000_0013, 32'h0000_0003);            // C held
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_head", bus.out_inst, 32'h0010_0013);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_order_B", bus.out_inst, 32'h0020_0013);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 3'b000, '0, '0);
        chk("bp_order_C", bus.out_inst, 32'h0030_0013);
        chk("bp_C_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // ---------------- streaming at count=1 ----------------
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h0000_0013, 32'h0000_0010);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stream%0d_inst", k), bus.out_inst,
                32'h0000_0013 | (32'(16 + k) << 20));
            chk($sformatf("stream%0d_rdy", k), 32'(bus.in_ready), 32'd1);
            drive(1'b1, 3'b001, 32'h0000_0013, 32'(17 + k));
        end
        drive(1'b0, 3'b000, '0, '0);
        @(posedge clk); #1;
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // ---------------- saturating counter (CNT_W=2) ----------------
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            @(posedge clk); #1;
            bus2.in_valid = 1'b0;
            chk($sformatf("sat%0d_cnt", k), 32'(err_count2), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h0000_0013, 32'h0000_0800);            // err entry
        repeat (2) @(posedge clk);
        #1;
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        chk("mr_errcnt_pre", 32'(err_count), 32'(exp_cnt + 2));
        @(negedge clk);
        drive(1'b0, 3'b000, '0, '0);
        rst = 1'b1;
        #1;
        chk("mr_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_err_count", 32'(err_count), 32'd0);
        chk("mr_out_inst", bus.out_inst, 32'd0);
        chk("mr_out_err", 32'(bus.out_err), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mr_in_ready_after", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 3'b101, 32'h0000_0073, 32'h0000_0005);
        @(posedge clk); #1;
        drive(1'b0, 3'b000, '0, '0);
        chk("mr_new_inst", bus.out_inst, 32'h0002_8073);
        chk("mr_new_err", 32'(bus.out_err), 32'd0);
        @(posedge clk); #1;
        chk("mr_no_stale", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decode: scatters a 32-bit immediate into a base instruction word using the RV32I immediate layouts.
- Also checks that the immediate is representable in the chosen format.
- Streaming block with valid/ready on both sides and a small output FIFO.
- Used by the trace/stimulus generator and the self-test patcher that builds instruction words on the fly.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, 2 or greater.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept; equals !full && !rst; independent of out_ready.
- in_imm  input  32  immediate value, two's complement.
- in_sel  input  3  format: 000 U, 001 I, 010 S, 011 B, 100 J, 101 Zimm (CSR).
- in_base  input  32  instruction with opcode/rd/rs/funct fields; immediate bit positions are ignored.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_inst  output  32  encoded instruction.
- out_err  output  1  immediate not representable in the selected format.
- err_count  output  CNT_W  number of accepted requests flagged err; saturating.

Behaviour:
- Accept on in_valid && in_ready. Pop on out_valid && out_ready.
- Encode is combinational on the inputs. The encoded word and err are written into the FIFO at acceptance.
- Latency: accepted at cycle N, visible at N+1 when the FIFO is empty.
- All bits outside the immediate field come from in_base.
- U: inst[31:12]=imm[31:12]. err if imm[11:0]!=0.
- I: inst[31:20]=imm[11:0]. err unless imm[31:11] are all equal.
- S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. Same range rule as I.
- B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]. err if imm[0]=1, or unless imm[31:12] are all equal.
- J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]. err if imm[0]=1, or unless imm[31:20] are all equal.
- Zimm: inst[19:15]=imm[4:0]. err if imm[31:5]!=0.
- sel 110/111: out_inst=in_base, err=1.
- On err the truncated encoding is still emitted. Nothing is dropped.
- Round-trip property: when err=0, decoding out_inst with the RV32I layout for the same sel returns in_imm exactly.
- FIFO:
  - Count register 0..DEPTH; full when count==DEPTH.
  - Push and pop in the same cycle keep count unchanged.
  - Push is impossible when full, so pop-while-full only decrements.
  - FIFO is strictly in order.
  - Read/write pointers wrap modulo DEPTH.
  - Head outputs are stable while out_valid && !out_ready.
- err_count increments at acceptance of an err entry. It holds at all ones (0xFFFF for CNT_W=16) and never wraps.
- Reset (including mid-operation), in the cycle after rst is sampled high:
  - count=0, pointers=0, out_valid=0, err_count=0.
  - out_inst/out_err: 0.
  - in_ready=0 while rst is high, then 1 in the first cycle after rst deasserts.
  - Entries held at reset are discarded.

Test Plan:
- I-type: base 0x00000013, imm 0xFFFFF800, sel 001, out_ready=1 -> next cycle out_valid=1, out_inst=0x80000013, out_err=0. Then imm 0x00000800 -> err=1, err_count=1.
- B-type: base 0x00000063, imm 0x00000FFE, sel 011 -> out_inst=0x7E000FE3, err=0. Then imm 0x00000003 -> err=1, err_count increments.
- U/J/Z:
  - U: base 0x000000B7, imm 0x12345000 -> 0x123450B7. imm 0x12345001 -> err=1.
  - J: base 0x0000006F, imm 0xFFFFFFFE -> 0xFFFFF06F, err=0.
  - Z: base 0x00000073, imm 0x1F -> 0x000F8073.
  - sel 111 -> out_inst=base, err=1.
- Backpressure: out_ready=0, offer 3 requests A/B/C back-to-back -> in_ready deasserts after 2 accepted, C held. Raise out_ready -> A, B, C emerge in order, one per cycle, with no loss or duplication.
- Simultaneous push/pop at count=1 with continuous traffic -> count stays 1 and throughput is 1 word/cycle. Force err_count to the all-ones value (0xFFFF), push an err entry -> stays 0xFFFF.
- Reset mid-operation: FIFO full, rst for 1 cycle -> next cycle out_valid=0, err_count=0, in_ready=0. The following cycle in_ready=1, and a new request emerges with no stale data.
